img_pattern_tx: RTL
===================

IMG_PATTERN_TX -- requirements
Module: img_pattern_tx

Interface
REQ-001 Parameter ImgWidth, default 2304, pixels per line; legal range >=1.
REQ-002 Parameter ImgHeight, default 1296, lines per frame; legal range >=1.
REQ-003 Parameter LineBlank, default 8, cycles with img_lv low between consecutive lines; legal range >=1.
REQ-004 Parameter FramePre, default 4, cycles with img_fv high before the first line; legal range >=1.
REQ-005 Parameter FramePost, default 4, cycles with img_fv high after the last line; legal range >=1.
REQ-006 Port clk, input, 1 bit: the block's only clock; one clock; all state on rising edge.
REQ-007 Port rst_, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port cmd_frame, input, 1 bit: toggle command; each change requests one frame.
REQ-009 Port status_frameDone, output, 1 bit: toggles once per completed frame.
REQ-010 Port status_pixelCount, output, 32 bits: pixels emitted in the most recent or current frame.
REQ-011 Port img_d, output, 12 bits: pixel data.
REQ-012 Port img_fv, output, 1 bit: frame valid.
REQ-013 Port img_lv, output, 1 bit: line valid; high only while img_fv is high.

Function
REQ-014 The block SHALL be the synthesizable transmitter of the sensor parallel interface consumed by the image capture path; all outputs SHALL be registered.
REQ-015 State machine SHALL have states Idle, Pre, Line, Blank, Post; Idle is the only state with img_fv low.
REQ-016 Idle SHALL compare cmd_frame to an internal copy; on mismatch it SHALL update the copy and enter Pre, with img_fv high after that same edge.
REQ-017 Pre SHALL hold img_fv high, img_lv low for FramePre cycles, then enter Line.
REQ-018 Line SHALL hold img_lv high for exactly ImgWidth cycles, presenting one pixel per cycle on img_d.
REQ-019 After a non-final line the block SHALL enter Blank for LineBlank cycles, then Line; after the final line it SHALL enter Post.
REQ-020 Post SHALL hold img_fv high, img_lv low for FramePost cycles, then return to Idle with img_fv low and toggle status_frameDone on that same edge.
REQ-021 Total img_fv-high cycles per frame SHALL equal FramePre + ImgHeight*ImgWidth + (ImgHeight-1)*LineBlank + FramePost.
REQ-022 The first pixel of each frame SHALL be 0x0FFF; each subsequent pixel SHALL be previous minus 1, modulo 2^12 (0x000 wraps to 0xFFF).
REQ-023 img_d SHALL be 0 whenever img_lv is low.
REQ-024 cmd_frame changes while not Idle SHALL NOT be latched immediately; the Idle comparison determines the next frame, so an odd number of toggles during a frame yields exactly one further frame and an even number yields none.
REQ-025 Line and row counters SHALL be sized to hold ImgWidth and ImgHeight without overflow.

Reset
REQ-026 While rst_ is low: state Idle, img_fv=0, img_lv=0, img_d=0, status_frameDone=0, status_pixelCount=0, internal cmd copy=0, all counters 0.
REQ-027 Reset asserted mid-frame SHALL drop img_fv/img_lv immediately and abandon the frame without toggling status_frameDone.
REQ-028 If cmd_frame is 1 when rst_ deasserts, a frame SHALL start at the first clock edge after deassertion.

Configuration
REQ-029 Macro IMG_PATTERN_TX_PIXCOUNT_EN defined: status_pixelCount SHALL clear on entry to Pre and increment on each img_lv-high cycle, saturating at 2^32-1.
REQ-030 Macro IMG_PATTERN_TX_PIXCOUNT_EN undefined: status_pixelCount SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification (ImgWidth=4, ImgHeight=2, LineBlank=2, FramePre=1, FramePost=1)
REQ-031 Single toggle of cmd_frame -> img_fv high 12 cycles; img_lv high 4, low 2, high 4; img_d 0x0FFF..0x0FF8; status_frameDone 0->1 as img_fv falls; status_pixelCount=8 (macro defined).
REQ-032 Second toggle after done -> identical frame restarting at 0x0FFF; status_frameDone 1->0.
REQ-033 Two toggles during an active frame -> no further frame after Post; three toggles -> exactly one further frame.
REQ-034 rst_ low during the second line -> img_fv/img_lv/img_d 0 asynchronously; status_frameDone stays 0; next toggle produces a full clean frame.
REQ-035 Build without IMG_PATTERN_TX_PIXCOUNT_EN, run REQ-031 stimulus -> same waveform, status_pixelCount stays 0.
REQ-036 ImgWidth=4096, ImgHeight=2 -> pixel 4097 is 0x0FFF again after wrapping through 0x000 and 0xFFF.

Source files
------------

// File: rtl/img_pattern_tx.sv
// Sensor parallel-interface pattern transmitter: one frame of decrementing 12-bit pixels per cmd_frame toggle.
// Define IMG_PATTERN_TX_PIXCOUNT_EN to enable the status_pixelCount counter (otherwise it is tied to 0).
module img_pattern_tx #(
    parameter int ImgWidth  = 2304,
    parameter int ImgHeight = 1296,
    parameter int LineBlank = 8,
    parameter int FramePre  = 4,
    parameter int FramePost = 4
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        cmd_frame,
    output logic        status_frameDone,
    output logic [31:0] status_pixelCount,
    output logic [11:0] img_d,
    output logic        img_fv,
    output logic        img_lv
);

    localparam int MaxA   = (ImgWidth > LineBlank) ? ImgWidth : LineBlank;
    localparam int MaxB   = (FramePre > FramePost) ? FramePre : FramePost;
    localparam int CntMax = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int RowW   = $clog2(ImgHeight + 1);

    localparam logic [CntW-1:0] PreLast   = CntW'(FramePre - 1);
    localparam logic [CntW-1:0] LineLast  = CntW'(ImgWidth - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(LineBlank - 1);
    localparam logic [CntW-1:0] PostLast  = CntW'(FramePost - 1);
    localparam logic [RowW-1:0] RowLast   = RowW'(ImgHeight - 1);

    typedef enum logic [2:0] {IDLE, PRE, LINE, BLANK, POST} state_t;

    state_t          state, state_nx;
    logic [CntW-1:0] cnt, cnt_nx;
    logic [RowW-1:0] row, row_nx;
    logic            cmd_copy, cmd_copy_nx;
    logic [11:0]     pix, pix_nx;
    logic [11:0]     img_d_nx;
    logic            done_nx;

    // cnt counts cycles within the current state; pix holds the next pixel to present
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + 1'b1;
        row_nx      = row;
        cmd_copy_nx = cmd_copy;
        pix_nx      = pix;
        done_nx     = status_frameDone;
        img_d_nx    = '0;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                row_nx = '0;
                if (cmd_frame != cmd_copy) begin
                    cmd_copy_nx = cmd_frame;
                    pix_nx      = 12'hFFF;
                    state_nx    = PRE;
                end
            end
            PRE: begin
                if (cnt == PreLast) begin
                    cnt_nx   = '0;
                    state_nx = LINE;
                end
            end
            LINE: begin
                if (cnt == LineLast) begin
                    cnt_nx   = '0;
                    row_nx   = row + 1'b1;
                    state_nx = (row == RowLast) ? POST : BLANK;
                end
            end
            BLANK: begin
                if (cnt == BlankLast) begin
                    cnt_nx   = '0;
                    state_nx = LINE;
                end
            end
            POST: begin
                if (cnt == PostLast) begin
                    cnt_nx   = '0;
                    row_nx   = '0;
                    done_nx  = ~status_frameDone;
                    state_nx = IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                row_nx   = '0;
                state_nx = IDLE;
            end
        endcase

        if (state_nx == LINE) begin
            img_d_nx = pix;
            pix_nx   = pix - 12'd1;
        end
    end

    // Outputs are derived from the next state so they line up with the registered state
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state            <= IDLE;
            cnt              <= '0;
            row              <= '0;
            cmd_copy         <= 1'b0;
            pix              <= '0;
            img_fv           <= 1'b0;
            img_lv           <= 1'b0;
            img_d            <= '0;
            status_frameDone <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            row              <= row_nx;
            cmd_copy         <= cmd_copy_nx;
            pix              <= pix_nx;
            img_fv           <= (state_nx != IDLE);
            img_lv           <= (state_nx == LINE);
            img_d            <= img_d_nx;
            status_frameDone <= done_nx;
        end
    end

`ifdef IMG_PATTERN_TX_PIXCOUNT_EN
    logic [31:0] pix_count;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pix_count <= '0;
        end else if (state == IDLE && state_nx == PRE) begin
            pix_count <= '0;
        end else if (state_nx == LINE && pix_count != 32'hFFFF_FFFF) begin
            pix_count <= pix_count + 32'd1;
        end
    end

    assign status_pixelCount = pix_count;
`else
    assign status_pixelCount = 32'd0;
`endif

endmodule
